// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first,
// repeated a latched number of times with an optional idle gap between
// repetitions. Moore FSM; every output comes straight from a flop.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             seqOut,
  output logic             seqValid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q,     state_d;
  logic [PAT_W-1:0] pat_q,       pat_d;
  logic [PAT_W-1:0] shift_q,     shift_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [CNT_W-1:0] reps_q,      reps_d;
  logic [GAP_W-1:0] gap_len_q,   gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic             seq_out_q,   seq_out_d;
  logic             seq_valid_q, seq_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  // Next-state and next-output logic; outputs default to the idle values.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    reps_d      = reps_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    seq_out_d   = 1'b0;
    seq_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      // Abort beats every transition; outputs fall to idle with no done pulse.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_d     = pattern;
            reps_d    = reps;
            gap_len_d = gap;
            busy_d    = 1'b1;
            if (reps != '0) begin
              state_d     = S_SHIFT;
              shift_d     = pattern;
              idx_d       = IDX_TOP;
              seq_out_d   = pattern[PAT_W-1];
              seq_valid_d = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end

        S_SHIFT: begin
          busy_d = 1'b1;
          if (idx_q != '0) begin
            // Next bit of the current repetition.
            idx_d       = idx_q - 1'b1;
            shift_d     = {shift_q[PAT_W-2:0], 1'b0};
            seq_out_d   = shift_q[PAT_W-2];
            seq_valid_d = 1'b1;
          end else if (reps_q == CNT_W'(1)) begin
            // Last bit of the last repetition is on the wire now.
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            reps_d = reps_q - 1'b1;
            if (gap_len_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_len_q;
            end else begin
              // Back-to-back: reload so the MSB follows with no bubble.
              shift_d     = pat_q;
              idx_d       = IDX_TOP;
              seq_out_d   = pat_q[PAT_W-1];
              seq_valid_d = 1'b1;
            end
          end
        end

        S_GAP: begin
          busy_d = 1'b1;
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_d     = S_SHIFT;
            gap_cnt_d   = '0;
            shift_d     = pat_q;
            idx_d       = IDX_TOP;
            seq_out_d   = pat_q[PAT_W-1];
            seq_valid_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end

        S_DONE: begin
          // Start is deliberately not sampled here; first IDLE cycle accepts it.
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      reps_q      <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      reps_q      <= reps_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seqOut   = seq_out_q;
  assign seqValid = seq_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen. Observed vector is {seqValid, seqOut, busy, done}.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [7:0] reps;
  logic [3:0] gap;
  logic       seqOut;
  logic       seqValid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .reps     (reps),
    .gap      (gap),
    .seqOut   (seqOut),
    .seqValid (seqValid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {seqValid, seqOut, busy, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed vobd=%b expected vobd=%b", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the negedge after the accepting edge.
  task automatic go(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    pattern = p;
    reps    = r;
    gap     = g;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Expect n valid bits, MSB first, one per cycle.
  task automatic stream(input string tag, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      chk(tag, {1'b1, bits[i], 1'b1, 1'b0});
      tick();
    end
  endtask

  task automatic gap_cycles(input string tag, input int g);
    for (int i = 0; i < g; i++) begin
      chk(tag, 4'b0010);
      tick();
    end
  endtask

  task automatic finish_run(input string tag);
    chk({tag, "_done"}, 4'b0011);
    tick();
    chk({tag, "_idle"}, 4'b0000);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    reps    = '0;
    gap     = '0;
    #12;
    chk("reset", 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_after_reset", 4'b0000);

    // 1: single repetition, busy for 5 cycles
    go(4'b1001, 8'd1, 4'd0);
    stream("t1_bits", 16'h0009, 4);
    finish_run("t1");

    // 2: three back-to-back repetitions
    tick();
    go(4'b1001, 8'd3, 4'd0);
    stream("t2_bits", 16'h0999, 12);
    finish_run("t2");

    // 3: two repetitions separated by a 3-cycle gap
    tick();
    go(4'b1010, 8'd2, 4'd3);
    stream("t3_rep1", 16'h000A, 4);
    gap_cycles("t3_gap", 3);
    stream("t3_rep2", 16'h000A, 4);
    finish_run("t3");

    // 4: zero repetitions -> done straight away
    tick();
    go(4'b1111, 8'd0, 4'd0);
    finish_run("t4");

    // 5: start held, pattern changed mid-run, restart, then abort
    tick();
    pattern = 4'b1100;
    reps    = 8'd2;
    gap     = 4'd0;
    start   = 1'b1;
    tick();
    pattern = 4'b0011;
    reps    = 8'd2;
    stream("t5_latched", 16'h00CC, 8);
    chk("t5_done", 4'b0011);
    tick();
    chk("t5_first_idle", 4'b0000);
    tick();
    chk("t5_restart_b3", 4'b1010);
    tick();
    chk("t5_restart_b2", 4'b1010);
    abort = 1'b1;
    tick();
    chk("t5_abort", 4'b0000);
    abort = 1'b0;
    start = 1'b0;
    tick();
    chk("t5_no_done", 4'b0000);
    abort = 1'b1;
    tick();
    chk("t5_abort_idle", 4'b0000);
    abort = 1'b0;
    tick();

    // 6: asynchronous reset in the middle of a gap
    go(4'b1010, 8'd2, 4'd3);
    stream("t6_rep1", 16'h000A, 4);
    chk("t6_gap", 4'b0010);
    tick();
    chk("t6_gap2", 4'b0010);
    #2 rst = 1'b0;
    #1 chk("t6_async_reset", 4'b0000);
    @(negedge clk);
    chk("t6_reset_held", 4'b0000);
    rst = 1'b1;
    tick();
    chk("t6_released", 4'b0000);
    go(4'b1001, 8'd1, 4'd0);
    stream("t6_bits", 16'h0009, 4);
    finish_run("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
